// File: rtl/dcache_pkg.sv
// Shared definitions for the write-back data cache: FSM states, MA-stage funct3
// encodings and block geometry.
package dcache_pkg;

    localparam int BLOCK_W  = 128;
    localparam int OFFSET_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE,
        S_FILL
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] F3_SB = 2'b00;
    localparam logic [1:0] F3_SH = 2'b01;
    localparam logic [1:0] F3_SW = 2'b10;

endpackage

// File: rtl/dcache_lane_sel.sv
// Byte/halfword/word extraction with sign or zero extension for loads, and
// byte-lane merge of store data into the addressed word.
module dcache_lane_sel
    import dcache_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  rd_f3_i,
    input  logic [1:0]  wr_f3_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;

    // Halfwords ignore ADDRESS[0]; misalignment is not trapped.
    assign byte_sel = word_i[{byte_off_i, 3'b000} +: 8];
    assign half_sel = word_i[{byte_off_i[1], 4'b0000} +: 16];

    always_comb begin
        rdata_o = word_i;
        case (rd_f3_i)
            F3_LB:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  rdata_o = {24'h0, byte_sel};
            F3_LHU:  rdata_o = {16'h0, half_sel};
            default: rdata_o = word_i;
        endcase
    end

    always_comb begin
        byte_en   = 4'b1111;
        wdata_rep = wdata_i;
        case (wr_f3_i)
            F3_SB: begin
                byte_en   = 4'b0001 << byte_off_i;
                wdata_rep = {4{wdata_i[7:0]}};
            end
            F3_SH: begin
                byte_en   = byte_off_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        merged_o = word_i;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) merged_o[i*8 +: 8] = wdata_rep[i*8 +: 8];
        end
    end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache between the MA stage and
// a 16-byte block memory. Hits complete in the same cycle; misses stall via BUSYWAIT.
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = 8,
    parameter int MEM_ADDR_W = 28
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [3:0]            READ,
    input  logic [2:0]            WRITE,
    input  logic [31:0]           ADDRESS,
    input  logic [31:0]           WRITEDATA,
    output logic [31:0]           READDATA,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
    output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]    MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = MEM_ADDR_W - IDX;

    state_e               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_q [NUM_LINES];
    logic [BLOCK_W-1:0]   fill_q;
    logic [31:0]          rdata_q, rdata_d;

    logic [IDX-1:0]       idx;
    logic [TAG_W-1:0]     tag;
    logic [1:0]           word_sel;
    logic                 access, hit, idle_hit, load_hit, store_hit;
    logic [BLOCK_W-1:0]   line_blk;
    logic [31:0]          line_word, ld_word, st_word;

    assign idx       = ADDRESS[OFFSET_W +: IDX];
    assign tag       = ADDRESS[OFFSET_W+IDX +: TAG_W];
    assign word_sel  = ADDRESS[3:2];
    assign line_blk  = data_q[idx];
    assign line_word = line_blk[{word_sel, 5'b00000} +: 32];

    assign access    = READ[3] | WRITE[2];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign idle_hit  = (state_q == S_IDLE) && hit;
    // A simultaneous load and store is treated as the store.
    assign store_hit = idle_hit && WRITE[2];
    assign load_hit  = idle_hit && READ[3] && !WRITE[2];

    dcache_lane_sel u_lane_sel (
        .word_i     (line_word),
        .rd_f3_i    (READ[2:0]),
        .wr_f3_i    (WRITE[1:0]),
        .byte_off_i (ADDRESS[1:0]),
        .wdata_i    (WRITEDATA),
        .rdata_o    (ld_word),
        .merged_o   (st_word)
    );

    // BUSYWAIT is gated by reset so an aborted miss releases the CPU at once.
    assign BUSYWAIT = RST && access && !idle_hit;
    assign READDATA = load_hit ? ld_word : rdata_q;
    assign rdata_d  = READDATA;

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        case (state_q)
            S_IDLE: begin
                if (access && !hit) state_d = dirty_q[idx] ? S_WRITEBACK : S_ALLOCATE;
                if (store_hit) dirty_d[idx] = 1'b1;
            end
            S_WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[idx], idx};
                MEM_WRITEDATA = line_blk;
                if (!MEM_BUSYWAIT) state_d = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[OFFSET_W +: MEM_ADDR_W];
                if (!MEM_BUSYWAIT) state_d = S_FILL;
            end
            S_FILL: begin
                valid_d[idx] = 1'b1;
                dirty_d[idx] = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage arrays and the fill buffer carry no reset; valid bits qualify them.
    always_ff @(posedge CLK) begin
        if (store_hit) data_q[idx][{word_sel, 5'b00000} +: 32] <= st_word;
        if (state_q == S_FILL) begin
            data_q[idx] <= fill_q;
            tag_q[idx]  <= tag;
        end
        if (state_q == S_ALLOCATE && !MEM_BUSYWAIT) fill_q <= MEM_READDATA;
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: table of CPU accesses with a block-memory
// model that pops expected transactions from a scoreboard queue.
module tb_dcache_wb;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [3:0]   READ = '0;
    logic [2:0]   WRITE = '0;
    logic [31:0]  ADDRESS = '0;
    logic [31:0]  WRITEDATA = '0;
    logic [31:0]  READDATA;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA = '0;
    logic         MEM_BUSYWAIT = 1'b1;

    always #5 CLK = ~CLK;

    dcache_wb #(.NUM_LINES(8), .MEM_ADDR_W(28)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    localparam logic [3:0] LB = 4'b1000, LH = 4'b1001, LW = 4'b1010;
    localparam logic [3:0] LBU = 4'b1100, LHU = 4'b1101, NR = 4'b0000;
    localparam logic [2:0] SB = 3'b100, SH = 3'b101, SW = 3'b110, NW = 3'b000;

    typedef struct {
        logic        wr;
        logic [27:0] addr;
        logic [31:0] w0;
    } mem_txn_t;

    typedef struct {
        string       name;
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          miss;
        bit          wb;
        logic [27:0] wb_addr;
        logic [31:0] wb_w0;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    mem_txn_t     exp_mem_q[$];
    logic [31:0]  exp_rd_q[$];
    vec_t         vecs[$];
    logic [127:0] mem [64];
    mem_txn_t     mtx;
    int           mem_lat = 2;
    int           mem_cnt = 0;
    bit           hold_mem = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] rd, input logic [2:0] wr,
                                input logic [31:0] addr, input logic [31:0] wdata, input bit miss,
                                input bit wb, input logic [27:0] wb_addr, input logic [31:0] wb_w0,
                                input logic [31:0] rdata, input int lat);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.miss = miss; v.wb = wb; v.wb_addr = wb_addr; v.wb_w0 = wb_w0;
        v.rdata = rdata; v.lat = lat;
        return v;
    endfunction

    // Block memory: completes a held request after mem_lat sampled cycles.
    always @(negedge CLK) begin
        if (!MEM_BUSYWAIT) begin
            MEM_BUSYWAIT = 1'b1;
            mem_cnt = 0;
        end else if ((MEM_READ || MEM_WRITE) && !hold_mem) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                if (exp_mem_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mem_unexpected: got wr=%0b addr=%0h, expected no transaction",
                             MEM_WRITE, MEM_ADDRESS);
                end else begin
                    mtx = exp_mem_q.pop_front();
                    check("mem_dir", MEM_WRITE, mtx.wr);
                    check("mem_addr", MEM_ADDRESS, mtx.addr);
                    if (mtx.wr) check("wb_word0", MEM_WRITEDATA[31:0], mtx.w0);
                end
                if (MEM_WRITE) mem[MEM_ADDRESS[5:0]] = MEM_WRITEDATA;
                else MEM_READDATA = mem[MEM_ADDRESS[5:0]];
                MEM_BUSYWAIT = 1'b0;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    task automatic apply(input vec_t v);
        int n;
        logic [31:0] exp_v;
        exp_v = '0;
        mem_lat = v.lat;
        if (v.miss) begin
            if (v.wb) exp_mem_q.push_back(mem_txn_t'{1'b1, v.wb_addr, v.wb_w0});
            exp_mem_q.push_back(mem_txn_t'{1'b0, v.addr[31:4], 32'h0});
        end
        if (v.rd[3]) exp_rd_q.push_back(v.rdata);
        READ = v.rd; WRITE = v.wr; ADDRESS = v.addr; WRITEDATA = v.wdata;
        #1;
        check({v.name, ":busy_now"}, BUSYWAIT, v.miss);
        if (!v.miss) check({v.name, ":no_memreq"}, {MEM_READ, MEM_WRITE}, 2'b00);
        n = 0;
        while (BUSYWAIT && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        if (BUSYWAIT) check({v.name, ":timeout"}, BUSYWAIT, 1'b0);
        else if (v.miss) check({v.name, ":miss_cycles"}, n, v.wb ? 3 + 2 * v.lat : 2 + v.lat);
        if (v.rd[3]) begin
            exp_v = exp_rd_q.pop_front();
            check({v.name, ":readdata"}, READDATA, exp_v);
        end
        @(posedge CLK); #1;
        READ = NR; WRITE = NW;
        #1;
        if (v.rd[3]) check({v.name, ":hold"}, READDATA, exp_v);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[4]  = {32'h0, 32'h0, 32'h5566_7788, 32'h1122_3344};
        mem[5]  = {32'h5A5A_0003, 32'h0, 32'h0, 32'hA5A5_A5A5};
        mem[8]  = {32'h0, 32'h0, 32'h0, 32'h0808_0808};
        mem[12] = {32'h0, 32'h0, 32'h0, 32'hCAFE_F00D};
        mem[20] = {32'h0, 32'h0, 32'h0, 32'h1122_3344};

        vecs.push_back(mk("lw40_miss",    LW,  NW, 32'h40,  0, 1, 0, 0, 0, 32'h1122_3344, 2));
        vecs.push_back(mk("lw44_hit",     LW,  NW, 32'h44,  0, 0, 0, 0, 0, 32'h5566_7788, 2));
        vecs.push_back(mk("sw40_hit",     NR,  SW, 32'h40,  32'hDEAD_BEEF, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk("lwc0_evict",   LW,  NW, 32'hC0,  0, 1, 1, 28'h4, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1));
        vecs.push_back(mk("lw40_refill",  LW,  NW, 32'h40,  0, 1, 0, 0, 0, 32'hDEAD_BEEF, 3));
        vecs.push_back(mk("sw40_pat",     NR,  SW, 32'h40,  32'h80FF_7F01, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk("lb40",         LB,  NW, 32'h40,  0, 0, 0, 0, 0, 32'h0000_0001, 2));
        vecs.push_back(mk("lb43",         LB,  NW, 32'h43,  0, 0, 0, 0, 0, 32'hFFFF_FF80, 2));
        vecs.push_back(mk("lbu43",        LBU, NW, 32'h43,  0, 0, 0, 0, 0, 32'h0000_0080, 2));
        vecs.push_back(mk("lh42",         LH,  NW, 32'h42,  0, 0, 0, 0, 0, 32'hFFFF_80FF, 2));
        vecs.push_back(mk("lhu42",        LHU, NW, 32'h42,  0, 0, 0, 0, 0, 32'h0000_80FF, 2));
        vecs.push_back(mk("lh40",         LH,  NW, 32'h40,  0, 0, 0, 0, 0, 32'h0000_7F01, 2));
        vecs.push_back(mk("lb42",         LB,  NW, 32'h42,  0, 0, 0, 0, 0, 32'hFFFF_FFFF, 2));
        vecs.push_back(mk("lbu41",        LBU, NW, 32'h41,  0, 0, 0, 0, 0, 32'h0000_007F, 2));
        vecs.push_back(mk("lw43",         LW,  NW, 32'h43,  0, 0, 0, 0, 0, 32'h80FF_7F01, 2));
        vecs.push_back(mk("lw140_evict",  LW,  NW, 32'h140, 0, 1, 1, 28'h4, 32'h80FF_7F01, 32'h1122_3344, 2));
        vecs.push_back(mk("sb141",        NR,  SB, 32'h141, 32'hFFFF_FFAB, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk("lw140_sb",     LW,  NW, 32'h140, 0, 0, 0, 0, 0, 32'h1122_AB44, 2));
        vecs.push_back(mk("sh142",        NR,  SH, 32'h142, 32'h1234_BEEF, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk("lw140_sh",     LW,  NW, 32'h140, 0, 0, 0, 0, 0, 32'hBEEF_AB44, 2));
        vecs.push_back(mk("lw50_idx5",    LW,  NW, 32'h50,  0, 1, 0, 0, 0, 32'hA5A5_A5A5, 1));
        vecs.push_back(mk("lw5c_hit",     LW,  NW, 32'h5C,  0, 0, 0, 0, 0, 32'h5A5A_0003, 2));
        vecs.push_back(mk("lw40_dirty",   LW,  NW, 32'h40,  0, 1, 1, 28'h14, 32'hBEEF_AB44, 32'h80FF_7F01, 2));
        vecs.push_back(mk("swc8_miss",    NR,  SW, 32'hC8,  32'h7777_7777, 1, 0, 0, 0, 0, 2));
        vecs.push_back(mk("lwc8_hit",     LW,  NW, 32'hC8,  0, 0, 0, 0, 0, 32'h7777_7777, 2));
        vecs.push_back(mk("lwc0_hit",     LW,  NW, 32'hC0,  0, 0, 0, 0, 0, 32'hCAFE_F00D, 2));
        vecs.push_back(mk("lw40_alloc_d", LW,  NW, 32'h40,  0, 1, 1, 28'hC, 32'hCAFE_F00D, 32'h80FF_7F01, 1));

        repeat (3) @(posedge CLK);
        #1;
        check("rst_busywait", BUSYWAIT, 1'b0);
        check("rst_mem_read", MEM_READ, 1'b0);
        check("rst_mem_write", MEM_WRITE, 1'b0);
        check("rst_readdata", READDATA, 32'h0);
        RST = 1'b1;
        @(posedge CLK); #1;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset in the middle of an allocate that memory never answers.
        hold_mem = 1'b1;
        READ = LW; ADDRESS = 32'h80;
        #1;
        check("abort:busy_now", BUSYWAIT, 1'b1);
        repeat (2) begin
            @(posedge CLK); #1;
        end
        check("abort:mem_read", MEM_READ, 1'b1);
        check("abort:mem_addr", MEM_ADDRESS, 28'h8);
        #1 RST = 1'b0;
        #1;
        check("abort:mem_read_drop", MEM_READ, 1'b0);
        check("abort:mem_write_drop", MEM_WRITE, 1'b0);
        check("abort:busy_drop", BUSYWAIT, 1'b0);
        check("abort:readdata_rst", READDATA, 32'h0);
        @(posedge CLK); #1;
        READ = NR;
        hold_mem = 1'b0;
        RST = 1'b1;
        @(posedge CLK); #1;
        apply(mk("lw40_after_rst", LW, NW, 32'h40, 0, 1, 0, 0, 0, 32'h80FF_7F01, 2));
        apply(mk("lw80_reissue",   LW, NW, 32'h80, 0, 1, 0, 0, 0, 32'h0808_0808, 2));

        repeat (2) @(posedge CLK);
        check("mem_queue_drained", exp_mem_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
